maf_exp_compare: RTL and testbench
==================================

Name: maf_exp_compare

Overview:
- Pipelined exponent/operation pre-stage of the general-precision multiply-add-fused (MAF) datapath, computing A*B + C.
- Sits directly upstream of the sign computation stage and the alignment shifter.
- Produces:
  - product sign (sign_a^sign_b)
  - effective-subtraction flag
  - exponent-comparison flag
  - result exponent candidate
  - saturated alignment shift amount
- Two register stages with valid/ready flow control, so the downstream pipeline can stall it.

Parameters:
- SIZE_EXP, 8, exponent field width.
- SIZE_MAN, 24, significand width including hidden bit.
- SHIFT_W, 6, width of align_shift; must hold 2*SIZE_MAN+2.

Ports:
- clk  input  1  clock, all registers on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  operand set present.
- ready_in  output  1  stage can accept the operand set this cycle.
- sign_a, sign_b, sign_c  input  1 each  operand signs.
- exp_a, exp_b, exp_c  input  SIZE_EXP each  biased exponents.
- valid_out  output  1  result registers hold a valid entry.
- ready_out  input  1  downstream accepts the entry this cycle.
- sign_ab  output  1  sign_a^sign_b.
- sign_c_o  output  1  registered sign_c.
- eff_sub  output  1  sign_a^sign_b^sign_c.
- comp_exp  output  1  product exponent strictly greater than exp_c.
- exp_eq  output  1  product exponent equals exp_c.
- exp_max  output  SIZE_EXP+2  signed max(exp_ab, exp_c).
- align_shift  output  SHIFT_W  |exp_ab - exp_c|, saturated to 2*SIZE_MAN+2.

Behaviour:
- Constants and widths:
  - BIAS = 2^(SIZE_EXP-1)-1.
  - exp_ab = exp_a + exp_b - BIAS, signed SIZE_EXP+2 bits, no overflow possible.
  - diff = exp_ab - exp_c, signed SIZE_EXP+3 bits. exp_c is zero-extended before subtraction.
- Stage 1 (S1 register):
  - Latches exp_ab, exp_c, sign_ab, sign_c and eff_sub.
  - Sets s1_valid.
- Stage 2 (S2 register, drives all outputs):
  - Computes diff from S1.
  - comp_exp = diff > 0.
  - exp_eq = diff == 0.
  - exp_max = comp_exp ? exp_ab : exp_c.
  - align_shift = min(|diff|, 2*SIZE_MAN+2). Default parameters saturate at 50.
- Latency: 2 cycles from accepted input to valid_out, with no stalls.
- Handshake:
  - Transfer occurs on valid & ready, both sides.
  - s2_adv = !valid_out | ready_out.
  - s1_adv = !s1_valid | s2_adv.
  - ready_in = s1_adv, combinational from register state and ready_out only.
  - S1 loads when s1_adv. s1_valid <= valid_in.
  - S2 loads when s2_adv. valid_out <= s1_valid.
  - Throughput is 1 operand set per cycle while ready_out = 1.
- Stall:
  - While valid_out = 1 and ready_out = 0, all S2 outputs hold stable.
  - S1 holds if it is occupied; ready_in = 0 when both stages are full.
  - No entry is dropped or duplicated.
- Bubbles: valid_in = 0 with s1_adv inserts a bubble. Data registers may hold stale values whenever the corresponding valid = 0.
- Simultaneous events: with full pipe, ready_out = 1 and valid_in = 1, both stages shift and the new entry is accepted in the same cycle.
- Reset:
  - rst_n low forces s1_valid = 0 and valid_out = 0 immediately.
  - All data registers and outputs go to 0.
  - Reset mid-operation discards in-flight entries.
  - First acceptance is possible on the first rising edge after rst_n deasserts.
- Special encodings (zero, inf, NaN) are not decoded here; they pass through as plain exponent arithmetic.

Test Plan:
1. Reset, then apply sign_a=0, sign_b=1, sign_c=0, exp_a=130, exp_b=127, exp_c=128, with ready_out=1. Required after 2 cycles:
   - valid_out=1, sign_ab=1, eff_sub=1
   - comp_exp=1, exp_eq=0
   - exp_max=130, align_shift=2
2. Apply exp_a=100, exp_b=127, exp_c=200. Required:
   - exp_ab=100, comp_exp=0, exp_eq=0
   - exp_max=200
   - align_shift=50 (saturated from 100)
3. Apply exp_a=127, exp_b=127, exp_c=127 with all signs 1. Required:
   - exp_eq=1, comp_exp=0, align_shift=0
   - sign_ab=0, eff_sub=1
4. Stream 5 back-to-back sets and hold ready_out=0 for cycles 3-6. Required:
   - ready_in=0 once both stages are full.
   - Outputs stay stable throughout the stall.
   - After release, all 5 results emerge in order, with no loss or duplication.
5. Apply exp_a=1, exp_b=1, exp_c=0. Required: exp_ab=-125 handled as signed, comp_exp=0, exp_max=0, align_shift=50.
6. Assert rst_n=0 asynchronously with 2 entries in flight. Required:
   - valid_out=0 and all outputs 0 without waiting for a clock edge.
   - No stale entry appears after reset is released.

Source files
------------

// File: rtl/maf_exp_compare.sv
// Exponent/operation pre-stage of the MAF datapath (A*B + C).
// Two registered stages with valid/ready flow control:
//   S1 latches the product exponent, exp_c and the sign/operation bits.
//   S2 compares exponents, selects the larger one and saturates the
//   alignment shift distance; S2 drives every output directly.
// Zero/inf/NaN encodings are not decoded here; they flow through as plain
// exponent arithmetic.
module maf_exp_compare #(
  parameter int unsigned SIZE_EXP = 8,
  parameter int unsigned SIZE_MAN = 24,
  parameter int unsigned SHIFT_W  = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,

  // Upstream handshake and operands
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic                       sign_a,
  input  logic                       sign_b,
  input  logic                       sign_c,
  input  logic [SIZE_EXP-1:0]        exp_a,
  input  logic [SIZE_EXP-1:0]        exp_b,
  input  logic [SIZE_EXP-1:0]        exp_c,

  // Downstream handshake and results
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic                       sign_ab,
  output logic                       sign_c_o,
  output logic                       eff_sub,
  output logic                       comp_exp,
  output logic                       exp_eq,
  output logic signed [SIZE_EXP+1:0] exp_max,
  output logic [SHIFT_W-1:0]         align_shift
);

  // Product exponent needs two extra bits: one for the carry of exp_a+exp_b,
  // one for the sign after removing the bias.
  localparam int unsigned ExpAbW   = SIZE_EXP + 2;
  // Difference needs one more bit than the product exponent.
  localparam int unsigned DiffW    = SIZE_EXP + 3;
  localparam int unsigned Bias     = (2 ** (SIZE_EXP - 1)) - 1;
  // Beyond this distance the smaller operand lands entirely in the sticky region.
  localparam int unsigned ShiftSat = 2 * SIZE_MAN + 2;

  // Elaboration-time guard: the shift port must be able to carry the saturation value.
  if (SHIFT_W < $clog2(ShiftSat + 1)) begin : g_shift_w_check
    $error("SHIFT_W too narrow to hold the saturated alignment shift");
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q;
  logic s2_valid_q;
  logic s1_adv;
  logic s2_adv;

  // S2 may load when it is empty or its entry leaves this cycle; S1 likewise
  // when empty or when S2 takes its entry. ready_in depends only on state and
  // ready_out so there is no combinational path from valid_in.
  always_comb begin
    s2_adv   = !s2_valid_q || ready_out;
    s1_adv   = !s1_valid_q || s2_adv;
    ready_in = s1_adv;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: product exponent and sign/operation bits
  // ---------------------------------------------------------------------------
  logic [ExpAbW-1:0]   exp_ab_d;
  logic                sign_ab_d;
  logic                eff_sub_d;

  logic [ExpAbW-1:0]   exp_ab_q;
  logic [SIZE_EXP-1:0] exp_c_q;
  logic                sign_ab_q;
  logic                sign_c_q;
  logic                eff_sub_q;

  // Unbiased-sum of the multiplicand exponents in two's complement; the
  // width leaves headroom so no overflow is possible for any input.
  always_comb begin
    exp_ab_d  = ExpAbW'(exp_a) + ExpAbW'(exp_b) - ExpAbW'(Bias);
    sign_ab_d = sign_a ^ sign_b;
    eff_sub_d = sign_a ^ sign_b ^ sign_c;
  end

  // S1 register: data loads whenever the stage advances, valid follows valid_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      exp_ab_q   <= '0;
      exp_c_q    <= '0;
      sign_ab_q  <= 1'b0;
      sign_c_q   <= 1'b0;
      eff_sub_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= valid_in;
      exp_ab_q   <= exp_ab_d;
      exp_c_q    <= exp_c;
      sign_ab_q  <= sign_ab_d;
      sign_c_q   <= sign_c;
      eff_sub_q  <= eff_sub_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: exponent comparison, max select and saturated shift distance
  // ---------------------------------------------------------------------------
  logic [DiffW-1:0]   diff;
  logic               diff_neg;
  logic [DiffW-1:0]   diff_abs;
  logic               comp_exp_d;
  logic               exp_eq_d;
  logic [ExpAbW-1:0]  exp_max_d;
  logic [SHIFT_W-1:0] align_shift_d;

  // diff = exp_ab - exp_c with exp_ab sign-extended and exp_c zero-extended.
  always_comb begin
    diff       = {exp_ab_q[ExpAbW-1], exp_ab_q} - DiffW'(exp_c_q);
    diff_neg   = diff[DiffW-1];
    diff_abs   = diff_neg ? (~diff + DiffW'(1)) : diff;
    exp_eq_d   = (diff == '0);
    comp_exp_d = !diff_neg && !exp_eq_d;
    exp_max_d  = comp_exp_d ? exp_ab_q : {2'b00, exp_c_q};
    if (diff_abs > DiffW'(ShiftSat)) begin
      align_shift_d = SHIFT_W'(ShiftSat);
    end else begin
      align_shift_d = diff_abs[SHIFT_W-1:0];
    end
  end

  logic               comp_exp_q;
  logic               exp_eq_q;
  logic [ExpAbW-1:0]  exp_max_q;
  logic [SHIFT_W-1:0] align_shift_q;
  logic               sign_ab_o_q;
  logic               sign_c_o_q;
  logic               eff_sub_o_q;

  // S2 register: holds every output stable while stalled by ready_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q    <= 1'b0;
      comp_exp_q    <= 1'b0;
      exp_eq_q      <= 1'b0;
      exp_max_q     <= '0;
      align_shift_q <= '0;
      sign_ab_o_q   <= 1'b0;
      sign_c_o_q    <= 1'b0;
      eff_sub_o_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q    <= s1_valid_q;
      comp_exp_q    <= comp_exp_d;
      exp_eq_q      <= exp_eq_d;
      exp_max_q     <= exp_max_d;
      align_shift_q <= align_shift_d;
      sign_ab_o_q   <= sign_ab_q;
      sign_c_o_q    <= sign_c_q;
      eff_sub_o_q   <= eff_sub_q;
    end
  end

  // Outputs come straight from the S2 registers.
  always_comb begin
    valid_out   = s2_valid_q;
    sign_ab     = sign_ab_o_q;
    sign_c_o    = sign_c_o_q;
    eff_sub     = eff_sub_o_q;
    comp_exp    = comp_exp_q;
    exp_eq      = exp_eq_q;
    exp_max     = $signed(exp_max_q);
    align_shift = align_shift_q;
  end

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // A stalled result must stay valid and unchanged until it is taken.
  property p_stall_hold;
    @(posedge clk) disable iff (!rst_n)
      (valid_out && !ready_out) |=>
        (valid_out && $stable({sign_ab, sign_c_o, eff_sub, comp_exp, exp_eq,
                               exp_max, align_shift}));
  endproperty
  a_stall_hold : assert property (p_stall_hold);

  // comp_exp and exp_eq are mutually exclusive.
  property p_cmp_exclusive;
    @(posedge clk) disable iff (!rst_n) valid_out |-> !(comp_exp && exp_eq);
  endproperty
  a_cmp_exclusive : assert property (p_cmp_exclusive);

endmodule

// File: tb/tb_maf_exp_compare.sv
// Scoreboard bench for maf_exp_compare: the driver pushes the hand-computed
// expected result of each accepted operand set; a monitor pops and compares
// whenever the DUT hands a result downstream.
module tb_maf_exp_compare;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              valid_in = 1'b0;
  logic              ready_in;
  logic              sign_a = 1'b0, sign_b = 1'b0, sign_c = 1'b0;
  logic [7:0]        exp_a = '0, exp_b = '0, exp_c = '0;
  logic              valid_out;
  logic              ready_out = 1'b0;
  logic              sign_ab, sign_c_o, eff_sub, comp_exp, exp_eq;
  logic signed [9:0] exp_max;
  logic [5:0]        align_shift;

  maf_exp_compare #(
    .SIZE_EXP (8),
    .SIZE_MAN (24),
    .SHIFT_W  (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .sign_a      (sign_a),
    .sign_b      (sign_b),
    .sign_c      (sign_c),
    .exp_a       (exp_a),
    .exp_b       (exp_b),
    .exp_c       (exp_c),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .sign_ab     (sign_ab),
    .sign_c_o    (sign_c_o),
    .eff_sub     (eff_sub),
    .comp_exp    (comp_exp),
    .exp_eq      (exp_eq),
    .exp_max     (exp_max),
    .align_shift (align_shift)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sa, sb, sc;
    int ea, eb, ec;
    bit x_sab, x_sc, x_eff, x_comp, x_eq;
    int x_max, x_shift;
  } vec_t;

  vec_t vecs[11];
  vec_t sb_q[$];
  vec_t e;
  int   tests = 0;
  int   fails = 0;

  logic [20:0] cur;
  logic [20:0] snap;
  bit          stall_prev = 1'b0;
  assign cur = {sign_ab, sign_c_o, eff_sub, comp_exp, exp_eq, exp_max, align_shift};

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Present one vector and hold it until the DUT accepts it.
  task automatic send(input int idx);
    sign_a   = vecs[idx].sa;
    sign_b   = vecs[idx].sb;
    sign_c   = vecs[idx].sc;
    exp_a    = 8'(vecs[idx].ea);
    exp_b    = 8'(vecs[idx].eb);
    exp_c    = 8'(vecs[idx].ec);
    valid_in = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ready_in) begin
        sb_q.push_back(vecs[idx]);
        @(posedge clk);
        #1;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: vector %0d not accepted within 50 cycles", idx);
  endtask

  // Wait until every expected result has been seen, bounded.
  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: check stall stability and compare every transferred result.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        tests++;
        if (!valid_out || cur != snap) begin
          fails++;
          $display("FAIL stall_hold: valid_out=%0b outputs=%h, required valid_out=1 outputs=%h",
                   valid_out, cur, snap);
        end
      end
      if (valid_out && ready_out) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: outputs=%h with empty scoreboard", cur);
        end else begin
          e = sb_q.pop_front();
          if (sign_ab != e.x_sab || sign_c_o != e.x_sc || eff_sub != e.x_eff ||
              comp_exp != e.x_comp || exp_eq != e.x_eq || int'(exp_max) != e.x_max ||
              int'(align_shift) != e.x_shift) begin
            fails++;
            $display({"FAIL result(%0d,%0d,%0d): got sab=%0b sc=%0b eff=%0b cmp=%0b eq=%0b ",
                      "max=%0d sh=%0d, required sab=%0b sc=%0b eff=%0b cmp=%0b eq=%0b ",
                      "max=%0d sh=%0d"},
                     e.ea, e.eb, e.ec, sign_ab, sign_c_o, eff_sub, comp_exp, exp_eq,
                     int'(exp_max), align_shift, e.x_sab, e.x_sc, e.x_eff, e.x_comp,
                     e.x_eq, e.x_max, e.x_shift);
          end
        end
      end
      stall_prev = valid_out && !ready_out;
      snap       = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            sa sb sc  ea   eb   ec   sab sc eff cmp eq  max  sh
    vecs[0]  = '{0, 1, 0, 130, 127, 128,  1, 0, 1, 1, 0, 130,  2};
    vecs[1]  = '{0, 0, 0, 100, 127, 200,  0, 0, 0, 0, 0, 200, 50};
    vecs[2]  = '{1, 1, 1, 127, 127, 127,  0, 1, 1, 0, 1, 127,  0};
    vecs[3]  = '{1, 1, 0,   1,   1,   0,  0, 0, 0, 0, 0,   0, 50};
    vecs[4]  = '{1, 0, 1, 177, 127, 127,  1, 1, 0, 1, 0, 177, 50};
    vecs[5]  = '{1, 0, 1, 177, 127, 128,  1, 1, 0, 1, 0, 177, 49};
    vecs[6]  = '{0, 0, 1, 140, 127, 100,  0, 1, 1, 1, 0, 140, 40};
    vecs[7]  = '{1, 0, 0, 127,  10,   5,  1, 0, 1, 1, 0,  10,  5};
    vecs[8]  = '{0, 1, 1, 200, 200,   0,  1, 1, 0, 1, 0, 273, 50};
    vecs[9]  = '{1, 1, 1, 255, 255, 255,  0, 1, 1, 1, 0, 383, 50};
    vecs[10] = '{0, 0, 0,   0,   0, 255,  0, 0, 0, 0, 0, 255, 50};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_outputs", int'(cur), 0);
    check("reset_ready_in", int'(ready_in), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-cycle latency on an empty pipe, then directed vectors back to back
    @(posedge clk);
    #1 ready_out = 1'b1;
    send(0);
    valid_in = 1'b0;
    check("latency_cycle1", int'(valid_out), 0);
    @(posedge clk);
    #1;
    check("latency_cycle2", int'(valid_out), 1);
    for (int i = 1; i <= 5; i++) send(i);
    valid_in = 1'b0;
    drain();

    // Five-entry stream with ready_out low across four edges
    fork
      begin
        for (int i = 6; i <= 10; i++) send(i);
        valid_in = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 ready_out = 1'b0;
        @(negedge clk);
        check("stall_full_ready_in", int'(ready_in), 0);
        check("stall_valid_out", int'(valid_out), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_late_ready_in", int'(ready_in), 0);
        @(posedge clk);
        #1 ready_out = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two entries in flight
    ready_out = 1'b0;
    send(0);
    send(1);
    valid_in = 1'b0;
    check("inflight_valid_out", int'(valid_out), 1);
    check("inflight_ready_in", int'(ready_in), 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid_out", int'(valid_out), 0);
    check("async_reset_outputs", int'(cur), 0);
    check("async_reset_ready_in", int'(ready_in), 1);
    sb_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_after_reset", int'(valid_out), 0);
    end
    @(posedge clk);
    #1;
    send(2);
    valid_in = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
